in_debounce: RTL and testbench

IN_DEBOUNCE -- requirements
Module: in_debounce

---
 rtl/in_debounce.sv | 135 +++++++++++++
 tb/tb_in_debounce.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/in_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : in_debounce
//  Brief    : Per-channel input synchronizer and debouncer with edge pulses
//             and a first-word fall-through event queue.
//  Revision : 1.0  initial release
// ============================================================================
module in_debounce #(
    parameter int WIDTH      = 8,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             evt_valid,
    output logic [3:0]       evt_data,
    input  logic             evt_ready,
    output logic             evt_overflow
);

    localparam int CNT_W = 4;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pend_dir;
    logic [WIDTH-1:0] push_mask;
    logic [WIDTH-1:0] push_clr;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [2:0]       push_ch;
    logic             have_pend;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_dir;
    logic [3:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // A channel is accepted on the edge its mismatch run reaches DEBOUNCE cycles.
    for (genvar i = 0; i < WIDTH; i++) begin : g_accept
        assign accept[i] = ena && (sync2[i] != dout[i]) && (cnt[i] == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!ena || (sync2[i] == dout[i]) || accept[i]) cnt[i] <= '0;
                else                                             cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout         <= '0;
            rise         <= '0;
            fall         <= '0;
            pending      <= '0;
            pend_dir     <= '0;
            evt_overflow <= 1'b0;
        end else begin
            dout     <= dout ^ accept;
            rise     <= accept & sync2;
            fall     <= accept & ~sync2;
            pending  <= (pending & ~push_clr) | accept;
            pend_dir <= (pend_dir & ~accept) | (accept & sync2);
            // Overwriting an entry that is not leaving this cycle loses an event.
            if (|(accept & pending & ~push_clr)) evt_overflow <= 1'b1;
        end
    end

    always_comb begin
        push_mask = '0;
        push_ch   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                push_mask    = '0;
                push_mask[i] = 1'b1;
                push_ch      = 3'(i);
            end
        end
    end

    assign have_pend = |pending;
    assign evt_valid = (occ != '0);
    assign full      = (occ == OCC_FULL);
    assign pop       = evt_valid && evt_ready;
    assign push      = have_pend && (!full || pop);
    assign push_clr  = push ? push_mask : '0;
    assign push_dir  = |(pend_dir & push_mask);
    assign evt_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {push_dir, push_ch};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_in_debounce.sv
`default_nettype none
// Testbench for in_debounce: table vectors, directed corner sequences and a
// randomized run compared against a window-based behavioural model.
`timescale 1ns/1ps
module tb_in_debounce;
    localparam int W     = 8;
    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int HMAX  = 8192;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         evt_valid;
    logic [3:0]   evt_data;
    logic         evt_ready;
    logic         evt_overflow;

    always #5 clk = ~clk;

    in_debounce #(.WIDTH(W), .DEBOUNCE(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ena(ena), .din(din), .dout(dout),
        .rise(rise), .fall(fall), .evt_valid(evt_valid), .evt_data(evt_data),
        .evt_ready(evt_ready), .evt_overflow(evt_overflow)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: raw input history indexed by edge number since reset.
    logic [W-1:0] din_h [HMAX];
    logic         ena_h [HMAX];
    int           n;
    int           last_acc [W];
    logic [W-1:0] m_dout, m_rise, m_fall, m_pend, m_dir;
    logic         m_ovf;
    logic [3:0]   m_q [$];

    typedef struct {
        logic       do_rst;
        logic [7:0] din;
        logic       ena;
        logic       rdy;
        logic [7:0] e_dout;
        logic [7:0] e_rise;
        logic [7:0] e_fall;
        logic       e_valid;
        logic [3:0] e_data;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic sync_at(input int j, input int ch);
        return (j >= 2) ? din_h[j-2][ch] : 1'b0;
    endfunction

    task automatic model_reset();
        n = 0;
        m_dout = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_dir = '0; m_ovf = 1'b0;
        m_q.delete();
        for (int c = 0; c < W; c++) last_acc[c] = 0;
    endtask

    task automatic model_update();
        logic [W-1:0] acc;
        logic [W-1:0] clr;
        logic         ok;
        logic         pop;
        logic         push;
        int           sel;
        n++;
        din_h[n] = din;
        ena_h[n] = ena;
        acc = '0;
        // Accept when the last D edges all saw ena and a level differing from dout.
        for (int c = 0; c < W; c++) begin
            if (n >= D) begin
                ok = 1'b1;
                for (int j = n - D + 1; j <= n; j++)
                    if (j <= last_acc[c] || !ena_h[j] || sync_at(j, c) == m_dout[c]) ok = 1'b0;
                acc[c] = ok;
            end
        end
        pop = (m_q.size() > 0) && evt_ready;
        sel = -1;
        for (int c = W - 1; c >= 0; c--) if (m_pend[c]) sel = c;
        push = (sel >= 0) && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        clr = '0;
        if (push) begin
            m_q.push_back({m_dir[sel], 3'(sel)});
            clr[sel] = 1'b1;
        end
        if (|(acc & m_pend & ~clr)) m_ovf = 1'b1;
        m_pend = (m_pend & ~clr) | acc;
        for (int c = 0; c < W; c++) begin
            if (acc[c]) begin
                m_dir[c]    = ~m_dout[c];
                last_acc[c] = n;
            end
        end
        m_rise = acc & ~m_dout;
        m_fall = acc & m_dout;
        m_dout = m_dout ^ acc;
    endtask

    task automatic model_chk();
        chk("model_dout", dout, m_dout);
        chk("model_rise", rise, m_rise);
        chk("model_fall", fall, m_fall);
        chk("model_valid", evt_valid, (m_q.size() > 0));
        chk("model_ovf", evt_overflow, m_ovf);
        if (m_q.size() > 0) chk("model_data", evt_data, m_q[0]);
    endtask

    task automatic step(input logic [W-1:0] d, input logic e, input logic r);
        din = d; ena = e; evt_ready = r;
        @(posedge clk);
        model_update();
        #1;
        model_chk();
    endtask

    task automatic do_reset();
        rst = 1'b1; din = '0; ena = 1'b1; evt_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("reset_dout", dout, 0);
        chk("reset_valid", evt_valid, 0);
        chk("reset_ovf", evt_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic void add_vec(input logic r0, input logic [7:0] d, input logic e, input logic rd,
                                    input logic [7:0] ed, input logic [7:0] er, input logic [7:0] ef,
                                    input logic ev, input logic [3:0] edat);
        vec_t v;
        v.do_rst = r0; v.din = d; v.ena = e; v.rdy = rd;
        v.e_dout = ed; v.e_rise = er; v.e_fall = ef; v.e_valid = ev; v.e_data = edat;
        tbl.push_back(v);
    endfunction

    initial begin
        int k;
        logic [W-1:0] rd;
        logic         re;
        logic         rr;
        logic [3:0]   exp_seq [5];
        rst = 1'b0; din = '0; ena = 1'b0; evt_ready = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        #1;
        chk("por_dout", dout, 0);
        chk("por_valid", evt_valid, 0);
        do_reset();

        // Single rise: dout/rise at edge 6, event visible at edge 7.
        add_vec(1, 8'h01, 1, 0, 8'h00, 8'h00, 8'h00, 0, 4'h0);
        for (int i = 2; i <= 5; i++) add_vec(0, 8'h01, 1, 0, 8'h00, 8'h00, 8'h00, 0, 4'h0);
        add_vec(0, 8'h01, 1, 0, 8'h01, 8'h01, 8'h00, 0, 4'h0);
        add_vec(0, 8'h01, 1, 0, 8'h01, 8'h00, 8'h00, 1, 4'b1000);
        add_vec(0, 8'h01, 1, 0, 8'h01, 8'h00, 8'h00, 1, 4'b1000);
        // Three-cycle glitch on ch3 is rejected.
        add_vec(1, 8'h08, 1, 0, 8'h00, 8'h00, 8'h00, 0, 4'h0);
        add_vec(0, 8'h08, 1, 0, 8'h00, 8'h00, 8'h00, 0, 4'h0);
        add_vec(0, 8'h08, 1, 0, 8'h00, 8'h00, 8'h00, 0, 4'h0);
        for (int i = 4; i <= 10; i++) add_vec(0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 4'h0);
        // Exactly DEBOUNCE-cycle pulse on ch3 is accepted, then falls back.
        add_vec(1, 8'h08, 1, 0, 8'h00, 8'h00, 8'h00, 0, 4'h0);
        for (int i = 2; i <= 4; i++) add_vec(0, 8'h08, 1, 0, 8'h00, 8'h00, 8'h00, 0, 4'h0);
        add_vec(0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 0, 4'h0);
        add_vec(0, 8'h00, 1, 0, 8'h08, 8'h08, 8'h00, 0, 4'h0);
        for (int i = 7; i <= 9; i++) add_vec(0, 8'h00, 1, 0, 8'h08, 8'h00, 8'h00, 1, 4'b1011);
        add_vec(0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h08, 1, 4'b1011);
        add_vec(0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 1, 4'b1011);

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) do_reset();
            step(tbl[i].din, tbl[i].ena, tbl[i].rdy);
            chk($sformatf("vec%0d_dout", i), dout, tbl[i].e_dout);
            chk($sformatf("vec%0d_rise", i), rise, tbl[i].e_rise);
            chk($sformatf("vec%0d_fall", i), fall, tbl[i].e_fall);
            chk($sformatf("vec%0d_valid", i), evt_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) chk($sformatf("vec%0d_data", i), evt_data, tbl[i].e_data);
        end

        // Simultaneous rises on ch2 and ch7 drain in index order.
        do_reset();
        for (int i = 1; i <= 8; i++) step(8'h84, 1, 0);
        chk("dual_head0", evt_data, 4'b1010);
        step(8'h84, 1, 1);
        chk("dual_head1", evt_data, 4'b1111);
        chk("dual_valid1", evt_valid, 1);
        step(8'h84, 1, 1);
        chk("dual_empty", evt_valid, 0);

        // Full queue, ch4 left pending, then overwritten by its own fall.
        do_reset();
        for (int i = 1; i <= 10; i++) step(8'h1F, 1, 0);
        chk("full_head", evt_data, 4'b1000);
        for (int i = 11; i <= 15; i++) step(8'h0F, 1, 0);
        chk("ovf_before", evt_overflow, 0);
        step(8'h0F, 1, 0);
        chk("ovf_set", evt_overflow, 1);
        chk("ovf_fall", fall, 8'h10);
        exp_seq[0] = 4'b1001; exp_seq[1] = 4'b1010; exp_seq[2] = 4'b1011; exp_seq[3] = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step(8'h0F, 1, 1);
            chk($sformatf("drain%0d_valid", i), evt_valid, 1);
            chk($sformatf("drain%0d_data", i), evt_data, exp_seq[i]);
        end
        step(8'h0F, 1, 1);
        chk("drain_empty", evt_valid, 0);
        chk("ovf_sticky", evt_overflow, 1);

        // Asynchronous reset between edges with the queue occupied.
        for (int i = 1; i <= 10; i++) step(8'hFF, 1, 0);
        chk("pre_arst_dout", dout, 8'hFF);
        chk("pre_arst_valid", evt_valid, 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_dout", dout, 8'h00);
        chk("arst_valid", evt_valid, 0);
        chk("arst_ovf", evt_overflow, 0);
        #1 rst = 1'b0;
        din = '0;

        // ena=0 holds off acceptance; release takes exactly DEBOUNCE edges.
        do_reset();
        for (int i = 1; i <= 10; i++) step(8'h02, 0, 0);
        chk("ena_hold", dout[1], 0);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            step(8'h02, 1, 0);
            if (dout[1] && k == 0) k = i;
        end
        chk("ena_latency", k, D);

        // Randomized traffic against the model.
        do_reset();
        rd = '0;
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < W; c++) if ($urandom_range(0, 5) == 0) rd[c] = ~rd[c];
            re = ($urandom_range(0, 7) != 0);
            rr = ($urandom_range(0, 2) == 0);
            step(rd, re, rr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
